// File: rtl/paddle_input_conditioner.sv
// Paddle button conditioner: 2-flop sync, per-button debounce, and a tick-paced move FSM.
// Define PADDLE_ACCEL_EN to enable the hold-to-accelerate speed ramp; otherwise every move is at speed 0.
module paddle_input_conditioner #(
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int ACCEL_TICKS    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_tick,
  input  logic       button_left_n,
  input  logic       button_right_n,
  output logic       left_level,
  output logic       right_level,
  output logic       move_valid,
  output logic       move_dir,
  output logic [1:0] move_speed
);

  localparam int CNT_W = $clog2(DEBOUNCE_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_COUNT - 1);

  typedef enum logic {IDLE, RAMP} moveState_t;

  // Index 1 is the left button, index 0 the right button.
  logic [1:0]       syncA;
  logic [1:0]       syncB;
  logic [1:0]       pressed;
  logic [1:0]       level;
  logic [CNT_W-1:0] debCount [2];

  moveState_t state;
  moveState_t nextState;
  logic       lastDir;
  logic       nextLastDir;
  logic       singlePress;
  logic       pressDir;
  logic       emit;

`ifdef PADDLE_ACCEL_EN
  localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ACCEL_TICKS - 1);

  logic [1:0]        speed;
  logic [1:0]        nextSpeed;
  logic [1:0]        emitSpeed;
  logic [HOLD_W-1:0] holdCnt;
  logic [HOLD_W-1:0] nextHoldCnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      syncA <= 2'b11;
      syncB <= 2'b11;
    end else begin
      syncA <= {button_left_n, button_right_n};
      syncB <= syncA;
    end
  end

  assign pressed = ~syncB;

  // A level flips only after DEBOUNCE_COUNT consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      level <= 2'b00;
      for (int i = 0; i < 2; i++) debCount[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (pressed[i] != level[i]) begin
          if (debCount[i] == CNT_LAST) begin
            level[i]    <= ~level[i];
            debCount[i] <= '0;
          end else begin
            debCount[i] <= debCount[i] + CNT_W'(1);
          end
        end else begin
          debCount[i] <= '0;
        end
      end
    end
  end

  assign left_level  = level[1];
  assign right_level = level[0];
  assign singlePress = level[1] ^ level[0];
  assign pressDir    = level[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      lastDir <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      speed   <= 2'd0;
      holdCnt <= '0;
`endif
    end else begin
      state   <= nextState;
      lastDir <= nextLastDir;
`ifdef PADDLE_ACCEL_EN
      speed   <= nextSpeed;
      holdCnt <= nextHoldCnt;
`endif
    end
  end

  // Everything holds between ticks; a reversal restarts the ramp exactly like a fresh press.
  always_comb begin
    nextState   = state;
    nextLastDir = lastDir;
    emit        = 1'b0;
`ifdef PADDLE_ACCEL_EN
    nextSpeed   = speed;
    nextHoldCnt = holdCnt;
    emitSpeed   = 2'd0;
`endif
    if (game_tick) begin
      if (!singlePress) begin
        nextState = IDLE;
`ifdef PADDLE_ACCEL_EN
        nextSpeed   = 2'd0;
        nextHoldCnt = '0;
`endif
      end else if (state == RAMP && pressDir == lastDir) begin
        emit = 1'b1;
`ifdef PADDLE_ACCEL_EN
        emitSpeed = speed;
        if (holdCnt == HOLD_LAST) begin
          nextHoldCnt = '0;
          if (speed != 2'd3) nextSpeed = speed + 2'd1;
        end else begin
          nextHoldCnt = holdCnt + HOLD_W'(1);
        end
`endif
      end else begin
        emit        = 1'b1;
        nextState   = RAMP;
        nextLastDir = pressDir;
`ifdef PADDLE_ACCEL_EN
        nextSpeed   = 2'd0;
        nextHoldCnt = HOLD_W'(1);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      move_valid <= 1'b0;
      move_dir   <= 1'b0;
`ifdef PADDLE_ACCEL_EN
      move_speed <= 2'd0;
`endif
    end else begin
      move_valid <= emit;
      if (emit) begin
        move_dir <= pressDir;
`ifdef PADDLE_ACCEL_EN
        move_speed <= emitSpeed;
`endif
      end
    end
  end

`ifndef PADDLE_ACCEL_EN
  assign move_speed = 2'd0;
`endif

endmodule

// File: tb/tb_paddle_input_conditioner.sv
// Bench for paddle_input_conditioner: directed scenarios plus random buttons/ticks/resets,
// compared every cycle against a window-based debounce and run-length speed model.
module tb_paddle_input_conditioner;

  localparam int DC = 8;
  localparam int AT = 4;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL_ON = 1'b1;
`else
  localparam bit ACCEL_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       gameTick = 1'b0;
  logic       rawL = 1'b1;
  logic       rawR = 1'b1;
  logic       leftLevel;
  logic       rightLevel;
  logic       moveValid;
  logic       moveDir;
  logic [1:0] moveSpeed;

  int passCount = 0;
  int failCount = 0;

  // Reference model state
  bit mLeft, mRight, mValid, mDir;
  int mSpeed;
  int runLen;
  bit runDir;
  bit rawL1, rawL2, rawR1, rawR2;
  bit histL[$];
  bit histR[$];

  paddle_input_conditioner #(
    .DEBOUNCE_COUNT(DC),
    .ACCEL_TICKS(AT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .game_tick(gameTick),
    .button_left_n(rawL),
    .button_right_n(rawR),
    .left_level(leftLevel),
    .right_level(rightLevel),
    .move_valid(moveValid),
    .move_dir(moveDir),
    .move_speed(moveSpeed)
  );

  always #5 clk = ~clk;

  // A level flips once the last DC pressed samples all disagree with it.
  function automatic bit windowFlips(input bit hist[$], input bit lvl);
    if (hist.size() < DC) return 1'b0;
    foreach (hist[i]) if (hist[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic modelEdge();
    bit pL;
    bit pR;
    if (rst) begin
      mLeft = 0; mRight = 0; mValid = 0; mDir = 0; mSpeed = 0;
      runLen = 0; runDir = 0;
      rawL1 = 1; rawL2 = 1; rawR1 = 1; rawR2 = 1;
      histL.delete();
      histR.delete();
    end else begin
      mValid = 0;
      if (gameTick) begin
        if (mLeft ^ mRight) begin
          if (runLen > 0 && mLeft == runDir) runLen++;
          else runLen = 1;
          runDir = mLeft;
          mValid = 1;
          mDir   = mLeft;
          mSpeed = ACCEL_ON ? (((runLen - 1) / AT) > 3 ? 3 : (runLen - 1) / AT) : 0;
        end else begin
          runLen = 0;
        end
      end
      pL = ~rawL2;
      pR = ~rawR2;
      rawL2 = rawL1; rawL1 = rawL;
      rawR2 = rawR1; rawR1 = rawR;
      histL.push_back(pL);
      histR.push_back(pR);
      if (histL.size() > DC) void'(histL.pop_front());
      if (histR.size() > DC) void'(histR.pop_front());
      if (windowFlips(histL, mLeft)) mLeft = ~mLeft;
      if (windowFlips(histR, mRight)) mRight = ~mRight;
    end
  endtask

  task automatic checkValue(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("left_level", {1'b0, leftLevel}, {1'b0, mLeft});
    checkValue("right_level", {1'b0, rightLevel}, {1'b0, mRight});
    checkValue("move_valid", {1'b0, moveValid}, {1'b0, mValid});
    checkValue("move_dir", {1'b0, moveDir}, {1'b0, mDir});
    checkValue("move_speed", moveSpeed, 2'(mSpeed));
  endtask

  task automatic applyStimulus(input bit tick);
    gameTick = tick;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0);
  endtask

  task automatic ticks(input int count, input int gap);
    repeat (count) begin
      idle(gap - 1);
      applyStimulus(1'b1);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_left"}, {1'b0, leftLevel}, 2'd0);
    checkValue({tag, "_right"}, {1'b0, rightLevel}, 2'd0);
    checkValue({tag, "_valid"}, {1'b0, moveValid}, 2'd0);
    checkValue({tag, "_dir"}, {1'b0, moveDir}, 2'd0);
    checkValue({tag, "_speed"}, moveSpeed, 2'd0);
  endtask

  initial begin
    $display("[TB] start, accel=%0d", ACCEL_ON);

    rst = 1'b1;
    repeat (3) applyStimulus(1'b1);
    checkAllZero("reset");
    rst = 1'b0;
    ticks(10, 16);

    rawL = 1'b0;
    idle(9);
    checkValue("debounce_k8", {1'b0, leftLevel}, 2'd0);
    idle(1);
    checkValue("debounce_k9", {1'b0, leftLevel}, 2'd1);
    rawL = 1'b1;
    idle(20);
    rawL = 1'b0;
    idle(5);
    rawL = 1'b1;
    idle(30);
    checkValue("glitch_left", {1'b0, leftLevel}, 2'd0);

    rawL = 1'b0;
    idle(12);
    repeat (8) begin
      ticks(1, 16);
      checkValue("cadence_valid", {1'b0, moveValid}, 2'd1);
      checkValue("cadence_dir", {1'b0, moveDir}, 2'd1);
      applyStimulus(1'b0);
      checkValue("cadence_single", {1'b0, moveValid}, 2'd0);
    end

    rawL = 1'b1;
    rawR = 1'b0;
    idle(12);
    for (int n = 1; n <= 16; n++) begin
      ticks(1, 16);
      checkValue("accel_dir", {1'b0, moveDir}, 2'd0);
      checkValue("accel_speed", moveSpeed, ACCEL_ON ? 2'((n <= 12) ? (n - 1) / 4 : 3) : 2'd0);
    end

    rawR = 1'b1;
    ticks(2, 16);
    rawR = 1'b0;
    idle(12);
    ticks(10, 16);
    rawR = 1'b1;
    rawL = 1'b0;
    idle(12);
    ticks(1, 4);
    checkValue("switch_dir", {1'b0, moveDir}, 2'd1);
    checkValue("switch_speed", moveSpeed, 2'd0);
    ticks(2, 16);

    rawR = 1'b0;
    idle(12);
    ticks(4, 16);
    rawR = 1'b1;
    idle(12);
    applyStimulus(1'b1);
    checkValue("after_both_valid", {1'b0, moveValid}, 2'd1);
    checkValue("after_both_speed", moveSpeed, 2'd0);

    ticks(14, 16);
    rst = 1'b1;
    applyStimulus(1'b1);
    checkAllZero("midramp_reset");
    rst = 1'b0;
    idle(9);
    checkValue("requalify_r9", {1'b0, leftLevel}, 2'd0);
    idle(1);
    checkValue("requalify_r10", {1'b0, leftLevel}, 2'd1);
    ticks(1, 3);
    checkValue("resume_speed", moveSpeed, 2'd0);
    ticks(6, 16);

    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 799) == 0);
      if ($urandom_range(0, 29) == 0) rawL = ~rawL;
      if ($urandom_range(0, 29) == 0) rawR = ~rawR;
      applyStimulus($urandom_range(0, 7) == 0);
    end
    rst = 1'b0;
    idle(4);

    $display("%0d/%0d checks passed", passCount, passCount + failCount);
    $finish;
  end

endmodule

// File: doc/paddle_input_conditioner.md
# paddle_input_conditioner

Conditions the two raw paddle push-buttons for the Pong game logic. It synchronises and debounces the normally-closed buttons, then turns held buttons into one paddle-move command per game tick, with an optional hold-to-accelerate speed ramp. It sits directly upstream of the paddle-position update in the Pong top level: that logic consumes `move_valid`/`move_dir`/`move_speed` instead of sampling the buttons directly.

## Interface
- `DEBOUNCE_COUNT`, default 50000: consecutive stable cycles required before a debounced level changes; must be ≥ 2.
- `ACCEL_TICKS`, default 32: moves emitted at each speed before stepping to the next speed.
- `clk`  input  1  system clock, the same clock that drives the Pong clock-divider counter.
- `rst`  input  1  reset, synchronous and active-high.
- `game_tick`  input  1  one-`clk`-cycle strobe, once per game update.
- `button_left_n`  input  1  raw left button, active-low (normally closed), asynchronous.
- `button_right_n`  input  1  raw right button, active-low (normally closed), asynchronous.
- `left_level`  output  1  debounced left-pressed level, active-high.
- `right_level`  output  1  debounced right-pressed level, active-high.
- `move_valid`  output  1  one-cycle move command.
- `move_dir`  output  1  1 = increase paddle location (left button), 0 = decrease (right button).
- `move_speed`  output  2  speed index 0..3; the consumer steps location by `(move_speed+1)*4` subpixels.

## Operation
- **Synchroniser:** a 2-flop synchroniser per button, reset to 1 (released). Each button's synchronised value is inverted to give a pressed value.
- **Debounce (per button):**
  - Counter width is `$clog2(DEBOUNCE_COUNT)`.
  - A cycle where the pressed value differs from the level is a mismatch cycle.
  - On a mismatch cycle with count `== DEBOUNCE_COUNT-1`: toggle the level and clear the count.
  - On any other mismatch cycle: increment the count.
  - On a match cycle: clear the count.
- **Move FSM:** two states, IDLE and RAMP. It also holds `last_dir`, `speed` (2 bits) and `hold_cnt` (`$clog2(ACCEL_TICKS)` bits). It is evaluated only in cycles where `game_tick` = 1; between ticks all state holds.
  - **Single press** means exactly one of `left_level`/`right_level` is high; its direction is `dir` (left → 1).
  - **IDLE, tick, single press:** emit a move at speed 0. Set `last_dir`=`dir`, `hold_cnt`=1, `speed`=0, go to RAMP.
  - **RAMP, tick, single press with `dir`==`last_dir`:** emit a move at the current `speed`.
    - If `hold_cnt==ACCEL_TICKS-1`: `hold_cnt`=0 and `speed`=min(`speed`+1, 3).
    - Otherwise: `hold_cnt`+1.
  - **RAMP, tick, single press with opposite `dir`:** behave exactly as the IDLE single-press case (speed 0, new direction).
  - **Any state, tick, with neither or both buttons pressed:** no move. Go to IDLE with `speed`=0 and `hold_cnt`=0. Both buttons held counts as no motion; neither button has priority.
- The `speed` value reported on `move_speed` is the value before any increment made on the same tick.

## Timing
- All outputs are registered. Reset values: `left_level`=0, `right_level`=0, `move_valid`=0, `move_dir`=0, `move_speed`=0. The FSM resets to IDLE.
- **Debounce latency:** if the raw input changes before clock edge k and then stays stable, the level changes at edge k+1+`DEBOUNCE_COUNT`.
- A glitch shorter than `DEBOUNCE_COUNT` synchronised cycles produces no level change.
- **Move latency:** `move_valid`, `move_dir` and `move_speed` are driven in the cycle after the `game_tick` cycle.
  - `move_valid` is high for exactly one cycle; `move_dir`/`move_speed` hold their values until the next move.
  - A level change in the same cycle as `game_tick` is not seen until the next tick.
- `rst` asserted mid-debounce or mid-ramp returns every register to its reset value at the next edge.
- A `game_tick` coincident with `rst` is ignored.
- `hold_cnt` never wraps past `ACCEL_TICKS-1`; `speed` saturates at 3.

## Configuration
- `PADDLE_ACCEL_EN` defined: hold-to-accelerate ramp as described above.
- `PADDLE_ACCEL_EN` undefined: the `speed` and `hold_cnt` registers are removed and `move_speed` is constant 0. Every move is at speed 0; the FSM and direction handling are unchanged.

## Test plan
- **Reset values:** pulse `rst`, buttons released (raw=1) → all outputs 0; no `move_valid` for 10 ticks.
- **Debounce, timing and glitch rejection:** `DEBOUNCE_COUNT`=8.
  - Drop `button_left_n` before edge k and hold low → `left_level` rises at edge k+9.
  - Separately, a 5-cycle low glitch → `left_level` stays 0.
- **Move cadence:** left held and debounced, `game_tick` every 16 cycles → `move_valid` pulses 1 cycle after each tick with `move_dir`=1, one pulse per tick.
- **Acceleration** (`PADDLE_ACCEL_EN`, `ACCEL_TICKS`=4): hold right → moves 1–4 at speed 0, 5–8 at speed 1, 9–12 at speed 2, 13 onward at speed 3.
- **Direction change and both held** (`ACCEL_TICKS`=4):
  - At speed 2, switch to left → next move has `move_dir`=1 and `move_speed`=0.
  - Then hold both buttons → no moves; release right → the next move is at speed 0.
- **Reset mid-ramp:** assert `rst` at speed 3 with left held → outputs go to 0. After release, moves resume only once `left_level` re-qualifies (`DEBOUNCE_COUNT`+1 cycles), starting at speed 0.
